// File: rtl/jk_reg_bank.sv
// Multi-bit JK/D/T/SR register bank with clear, parallel load, global enable,
// registered edge-detect outputs and a saturating change counter.
module jk_reg_bank #(
  parameter int                 WIDTH           = 8,
  parameter logic [WIDTH-1:0]   RST_VAL         = {WIDTH{1'b0}},
  parameter bit                 SR_SET_PRIORITY = 1'b1,
  parameter int                 CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  j,
  input  logic [WIDTH-1:0]  k,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  rise,
  output logic [WIDTH-1:0]  fall,
  output logic              changed,
  output logic [CNT_W-1:0]  toggle_cnt
);

  localparam logic [1:0]       MODE_JK = 2'b00;
  localparam logic [1:0]       MODE_D  = 2'b01;
  localparam logic [1:0]       MODE_T  = 2'b10;
  localparam logic [1:0]       MODE_SR = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mode_nq_s;
  logic [WIDTH-1:0] nq_s;

  // Per-bit next state for the selected flip-flop flavour.
  always_comb begin
    mode_nq_s = q_q;
    case (mode)
      MODE_JK: mode_nq_s = (j & ~q_q) | (~k & q_q);
      MODE_D:  mode_nq_s = j;
      MODE_T:  mode_nq_s = j ^ q_q;
      MODE_SR: begin
        if (SR_SET_PRIORITY) begin
          mode_nq_s = j | (~k & q_q);
        end else begin
          mode_nq_s = ~k & (j | q_q);
        end
      end
      default: mode_nq_s = q_q;
    endcase
  end

  // Priority resolution and edge/counter bookkeeping; clr zeroes everything
  // including the counter, so it sits outside the normal change accounting.
  always_comb begin
    nq_s      = q_q;
    q_d       = q_q;
    rise_d    = {WIDTH{1'b0}};
    fall_d    = {WIDTH{1'b0}};
    changed_d = 1'b0;
    cnt_d     = cnt_q;
    if (clr) begin
      q_d   = RST_VAL;
      cnt_d = {CNT_W{1'b0}};
    end else begin
      if (load) begin
        nq_s = load_val;
      end else if (en) begin
        nq_s = mode_nq_s;
      end else begin
        nq_s = q_q;
      end
      q_d       = nq_s;
      rise_d    = nq_s & ~q_q;
      fall_d    = ~nq_s & q_q;
      changed_d = |(nq_s ^ q_q);
      if (changed_d && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q       <= RST_VAL;
      rise_q    <= {WIDTH{1'b0}};
      fall_q    <= {WIDTH{1'b0}};
      changed_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      q_q       <= q_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign q          = q_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign changed    = changed_q;
  assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank: default instance, a reset-priority SR
// instance and a 2-bit counter instance, all driven by the same inputs.
module tb_jk_reg_bank;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j, k, load_val;
  logic       clr, load;

  logic [7:0] q_a, rise_a, fall_a, cnt_a;
  logic       ch_a;
  logic [7:0] q_b, rise_b, fall_b, cnt_b;
  logic       ch_b;
  logic [7:0] q_c, rise_c, fall_c;
  logic [1:0] cnt_c;
  logic       ch_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_reg_bank dut_a (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .j(j), .k(k), .clr(clr),
    .load(load), .load_val(load_val), .q(q_a), .rise(rise_a), .fall(fall_a),
    .changed(ch_a), .toggle_cnt(cnt_a)
  );

  jk_reg_bank #(.SR_SET_PRIORITY(1'b0)) dut_b (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .j(j), .k(k), .clr(clr),
    .load(load), .load_val(load_val), .q(q_b), .rise(rise_b), .fall(fall_b),
    .changed(ch_b), .toggle_cnt(cnt_b)
  );

  jk_reg_bank #(.CNT_W(2)) dut_c (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .j(j), .k(k), .clr(clr),
    .load(load), .load_val(load_val), .q(q_c), .rise(rise_c), .fall(fall_c),
    .changed(ch_c), .toggle_cnt(cnt_c)
  );

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] lv;
    logic [7:0] eq;
    logic [7:0] er;
    logic [7:0] ef;
    logic       ec;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic [1:0] m,
                       input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] lv);
    clr = c; load = l; en = e; mode = m; j = jj; k = kk; load_val = lv;
  endtask

  task automatic step(input logic c, input logic l, input logic e, input logic [1:0] m,
                      input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] lv);
    drive(c, l, e, m, jj, kk, lv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            clr   load  en    mode   j      k      lv     q      rise   fall   ch    cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'b00, 8'hF0, 8'h0F, 8'h00, 8'hF0, 8'hF0, 8'h00, 1'b1, 8'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h0F, 8'h0F, 8'hF0, 1'b1, 8'd2};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 1'b0, 8'd2};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'b01, 8'hA5, 8'hFF, 8'h00, 8'hA5, 8'hA0, 8'h0A, 1'b1, 8'd3};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'b10, 8'h0F, 8'hFF, 8'h00, 8'hAA, 8'h0A, 8'h05, 1'b1, 8'd4};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'hAA, 8'h00, 8'h00, 1'b0, 8'd4};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h55, 8'h55, 8'h55, 8'hAA, 1'b1, 8'd5};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'b00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h00, 1'b1, 8'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 2'b11, 8'h03, 8'h06, 8'h00, 8'h03, 8'h03, 8'h00, 1'b1, 8'd1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'h00, 8'h00, 1'b0, 8'd1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 1'b0, 8'd1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 2'b11, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h01, 1'b1, 8'd2};

    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    #2;
    chk("por_q",    {24'd0, q_a},    32'h00);
    chk("por_rise", {24'd0, rise_a}, 32'h00);
    chk("por_cnt",  {24'd0, cnt_a},  32'h00);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].mode, vecs[i].j, vecs[i].k, vecs[i].lv);
      chk($sformatf("vec%0d_q", i),    {24'd0, q_a},    {24'd0, vecs[i].eq});
      chk($sformatf("vec%0d_rise", i), {24'd0, rise_a}, {24'd0, vecs[i].er});
      chk($sformatf("vec%0d_fall", i), {24'd0, fall_a}, {24'd0, vecs[i].ef});
      chk($sformatf("vec%0d_chg", i),  {31'd0, ch_a},   {31'd0, vecs[i].ec});
      chk($sformatf("vec%0d_cnt", i),  {24'd0, cnt_a},  {24'd0, vecs[i].ecnt});
    end

    // SR conflict on both priority settings.
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 2'b11, 8'h03, 8'h06, 8'h00);
    chk("sr_setpri_q", {24'd0, q_a}, 32'h03);
    chk("sr_rstpri_q", {24'd0, q_b}, 32'h01);
    chk("sr_rstpri_rise", {24'd0, rise_b}, 32'h01);

    // Counter saturation on the 2-bit instance.
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    for (int n = 1; n <= 5; n++) begin
      step(1'b0, 1'b0, 1'b1, 2'b10, 8'h01, 8'h00, 8'h00);
      chk($sformatf("sat%0d_cnt", n),  {30'd0, cnt_c}, (n >= 3) ? 32'd3 : n);
      chk($sformatf("sat%0d_q", n),    {24'd0, q_c},   (n % 2 == 1) ? 32'h01 : 32'h00);
      chk($sformatf("sat%0d_rise", n), {24'd0, rise_c}, (n % 2 == 1) ? 32'h01 : 32'h00);
      chk($sformatf("sat%0d_fall", n), {24'd0, fall_c}, (n % 2 == 0) ? 32'h01 : 32'h00);
      chk($sformatf("sat%0d_wide_cnt", n), {24'd0, cnt_a}, n);
    end

    // Asynchronous reset between edges, held across an edge with load pending.
    step(1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h5A);
    chk("pre_rst_q", {24'd0, q_a}, 32'h5A);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_q",    {24'd0, q_a},    32'h00);
    chk("async_rst_rise", {24'd0, rise_a}, 32'h00);
    chk("async_rst_fall", {24'd0, fall_a}, 32'h00);
    chk("async_rst_chg",  {31'd0, ch_a},   32'h0);
    chk("async_rst_cnt",  {24'd0, cnt_a},  32'h00);
    drive(1'b0, 1'b1, 1'b1, 2'b00, 8'hFF, 8'h00, 8'h77);
    @(posedge clk);
    #1;
    chk("rst_hold_q", {24'd0, q_a}, 32'h00);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_q",    {24'd0, q_a},    32'h77);
    chk("post_rst_rise", {24'd0, rise_a}, 32'h77);
    chk("post_rst_cnt",  {24'd0, cnt_a},  32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
